// File: rtl/t_ff_seq_ctrl.sv
// T flip-flop bank sequencer: owns q, emits the toggle vector t_en,
// and runs the bank as a preloadable up/down counter for N steps.
module t_ff_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             up,
    input  logic [CW-1:0]    steps,
    input  logic             halt,
    output logic [WIDTH-1:0] t_en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_ten;
    logic [WIDTH-1:0] w_low1;
    logic [WIDTH-1:0] w_low0;
    logic [WIDTH-1:0] w_cnt_vec;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;

    // Bit i toggles when all lower bits are ones (up) or zeros (down)
    assign w_low1[0] = 1'b1;
    assign w_low0[0] = 1'b1;

    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_prefix
        assign w_low1[gi] = w_low1[gi-1] & r_q[gi-1];
        assign w_low0[gi] = w_low0[gi-1] & ~r_q[gi-1];
    end

    assign w_cnt_vec = r_dir ? w_low1 : w_low0;

    always_comb begin
        w_next     = r_state;
        w_ten      = '0;
        w_cnt_nxt  = r_cnt;
        w_dir_nxt  = r_dir;
        w_wrap_nxt = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_ten = r_q ^ load_val;
                end else if (start) begin
                    w_dir_nxt = up;
                    w_cnt_nxt = steps;
                    w_next    = (steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (halt) begin
                    w_next    = S_IDLE;
                    w_cnt_nxt = '0;
                end else begin
                    w_ten      = w_cnt_vec;
                    w_cnt_nxt  = r_cnt - CW'(1);
                    w_wrap_nxt = r_dir ? (&r_q) : ~(|r_q);
                    if (r_cnt == CW'(1)) begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_q     <= r_q ^ w_ten;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign t_en = w_ten;
    assign q    = r_q;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign wrap = r_wrap;

endmodule

// File: tb/tb_t_ff_seq_ctrl.sv
// Bench for t_ff_seq_ctrl: directed vector table, mid-run reset,
// then random traffic against a counter-level reference model.
module tb_t_ff_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CW    = 8;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             Clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             up;
    logic [CW-1:0]    steps;
    logic             halt;
    logic [WIDTH-1:0] t_en;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;

    t_ff_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .Clk      (Clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .up       (up),
        .steps    (steps),
        .halt     (halt),
        .t_en     (t_en),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        bit       ld;
        bit [3:0] lv;
        bit       st;
        bit       u;
        bit [7:0] n;
        bit       h;
        bit [3:0] e_ten;
        bit [3:0] e_q;
        bit       e_busy;
        bit       e_done;
        bit       e_wrap;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: 0 idle, 1 running, 2 done-pulse cycle
    int m_mode;
    int m_q;
    int m_left;
    int m_dir;
    int m_wrap;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic add(input bit ld, input bit [3:0] lv, input bit st,
                       input bit u, input bit [7:0] n, input bit h,
                       input bit [3:0] et, input bit [3:0] eq,
                       input bit eb, input bit ed, input bit ew);
        vec_t v;
        v = '{ld, lv, st, u, n, h, et, eq, eb, ed, ew};
        tbl.push_back(v);
    endtask

    task automatic drive(input bit ld, input bit [3:0] lv, input bit st,
                         input bit u, input bit [7:0] n, input bit h);
        load     = ld;
        load_val = lv;
        start    = st;
        up       = u;
        steps    = n;
        halt     = h;
    endtask

    function automatic int nxt(input int qq, input int d);
        return d != 0 ? (qq + 1) & MASK : (qq - 1) & MASK;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_q    = 0;
        m_left = 0;
        m_dir  = 0;
        m_wrap = 0;
    endtask

    function automatic int model_ten();
        if (m_mode == 0 && load)
            return m_q ^ int'(load_val);
        if (m_mode == 1 && !halt)
            return m_q ^ nxt(m_q, m_dir);
        return 0;
    endfunction

    task automatic model_upd();
        int nw;
        nw = 0;
        case (m_mode)
            0: begin
                if (load) begin
                    m_q = int'(load_val);
                end else if (start) begin
                    m_dir  = int'(up);
                    m_left = int'(steps);
                    m_mode = (steps == 0) ? 2 : 1;
                end
            end
            1: begin
                if (halt) begin
                    m_mode = 0;
                end else begin
                    if ((m_dir != 0 && m_q == MASK) || (m_dir == 0 && m_q == 0))
                        nw = 1;
                    m_q = nxt(m_q, m_dir);
                    m_left--;
                    if (m_left == 0)
                        m_mode = 2;
                end
            end
            default: m_mode = 0;
        endcase
        m_wrap = nw;
    endtask

    task automatic model_step(input string tag);
        @(negedge Clk);
        chk({tag, " t_en"}, 32'(t_en), 32'(model_ten()));
        chk({tag, " q"}, 32'(q), 32'(m_q));
        chk({tag, " busy"}, 32'(busy), 32'(m_mode == 1));
        chk({tag, " done"}, 32'(done), 32'(m_mode == 2));
        chk({tag, " wrap"}, 32'(wrap), 32'(m_wrap));
        @(posedge Clk);
        model_upd();
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // ld lv st u n h | t_en q busy done wrap
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);
        add(1, 3, 0, 0, 0, 0, 4'h3, 4'h0, 0, 0, 0);
        add(0, 0, 1, 1, 5, 0, 4'h0, 4'h3, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h7, 4'h3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h1, 4'h4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h3, 4'h5, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h1, 4'h6, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'hF, 4'h7, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h8, 0, 1, 0);
        add(1, 1, 0, 0, 0, 0, 4'h9, 4'h8, 0, 0, 0);
        add(0, 0, 1, 0, 3, 0, 4'h0, 4'h1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h1, 4'h1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'hF, 4'h0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h1, 4'hF, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'hE, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 4'hE, 4'hE, 0, 0, 0);
        add(0, 0, 1, 1, 10, 0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h1, 4'h0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h3, 4'h1, 1, 0, 0);
        add(1, 5, 1, 0, 0, 0, 4'h1, 4'h2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h7, 4'h3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 4'h0, 4'h4, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h4, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h4, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 4'h0, 4'h4, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h4, 0, 0, 0);
        add(1, 15, 0, 0, 0, 0, 4'hB, 4'h4, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 4'h0, 4'hF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'hF, 4'hF, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge Clk);
        #1;
        chk("reset q", 32'(q), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset t_en", 32'(t_en), 32'h0);
        chk("reset wrap", 32'(wrap), 32'h0);
        @(negedge Clk);
        rst = 1'b1;
        @(posedge Clk);
        #1;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ld, tbl[i].lv, tbl[i].st,
                  tbl[i].u, tbl[i].n, tbl[i].h);
            @(negedge Clk);
            chk($sformatf("vec%0d t_en", i), 32'(t_en), 32'(tbl[i].e_ten));
            chk($sformatf("vec%0d q", i), 32'(q), 32'(tbl[i].e_q));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("vec%0d wrap", i), 32'(wrap), 32'(tbl[i].e_wrap));
            @(posedge Clk);
            #1;
        end

        // Mid-run asynchronous reset
        drive(0, 0, 1, 1, 8, 0);
        @(posedge Clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge Clk);
        #1;
        chk("pre-reset busy", 32'(busy), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst q", 32'(q), 32'h0);
        chk("midrst busy", 32'(busy), 32'h0);
        chk("midrst done", 32'(done), 32'h0);
        chk("midrst t_en", 32'(t_en), 32'h0);
        @(negedge Clk);
        rst = 1'b1;
        @(posedge Clk);
        #1;
        model_reset();
        for (int i = 0; i < 12; i++)
            model_step("post-reset");

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) == 0,
                  4'($urandom),
                  $urandom_range(0, 4) == 0,
                  1'($urandom),
                  8'($urandom_range(0, 20)),
                  $urandom_range(0, 19) == 0);
            model_step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
